// File: rtl/prbs_gen_multi.sv
// prbs_gen_multi: run-time selectable PRBS7/15/23/31 word generator with seed load,
// single-shot and periodic bit-0 error injection, and a saturating corrupted-word count.
module prbs_gen_multi #(
    parameter int          WIDTH = 32,
    parameter logic [30:0] SEED  = 31'h7FFFFFFF,
    parameter int          PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       poly_sel,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    input  logic             inj_err,
    input  logic [PER_W-1:0] err_period,
    output logic [WIDTH-1:0] prbs,
    output logic             prbs_valid,
    output logic [31:0]      err_cnt
);
    logic [30:0]      state_q, state_d, lfsr, ld_seed;
    logic [1:0]       poly_q, poly_d;
    logic             pend_q, pend_d, valid_q, step, hit, flip, fb;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d, per_q, per_d, p_eff;
    logic [WIDTH-1:0] prbs_q, prbs_d, word;
    logic [31:0]      err_cnt_q, err_cnt_d;

    function automatic logic [30:0] pmask(input logic [1:0] p);
        return p == 2'd0 ? 31'h7F : p == 2'd1 ? 31'h7FFF : p == 2'd2 ? 31'h7FFFFF : 31'h7FFFFFFF;
    endfunction

    function automatic logic tap(input logic [30:0] s, input logic [1:0] p);
        return p == 2'd0 ? s[6] ^ s[5] : p == 2'd1 ? s[14] ^ s[13] : p == 2'd2 ? s[22] ^ s[17] : s[30] ^ s[27];
    endfunction

    // WIDTH Fibonacci steps per cycle; the first bit in time lands in the MSB
    always_comb begin
        lfsr = state_q;
        word = '0;
        fb   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            fb                = tap(lfsr, poly_q);
            lfsr              = {lfsr[29:0], fb} & pmask(poly_q);
            word[WIDTH-1-i]   = fb;
        end
    end

    // The period is sampled only at the start of each interval, so changes apply after a wrap
    always_comb begin
        step      = en & ~seed_load;
        p_eff     = per_cnt_q == '0 ? err_period : per_q;
        hit       = (p_eff != '0) && (per_cnt_q == p_eff - PER_W'(1));
        flip      = step & (pend_q | hit);
        ld_seed   = seed & pmask(poly_sel);
        state_d   = seed_load ? (ld_seed == '0 ? pmask(poly_sel) : ld_seed) : step ? lfsr : state_q;
        poly_d    = seed_load ? poly_sel : poly_q;
        pend_d    = inj_err | (pend_q & ~step);
        per_cnt_d = seed_load ? '0 : !step ? per_cnt_q : (p_eff == '0 || hit) ? '0 : per_cnt_q + PER_W'(1);
        per_d     = step ? p_eff : per_q;
        prbs_d    = step ? word ^ WIDTH'(flip) : prbs_q;
        err_cnt_d = (flip && err_cnt_q != '1) ? err_cnt_q + 32'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            poly_q    <= 2'b11;
            pend_q    <= 1'b0;
            per_cnt_q <= '0;
            per_q     <= '0;
            prbs_q    <= '0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            poly_q    <= poly_d;
            pend_q    <= pend_d;
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
            prbs_q    <= prbs_d;
            valid_q   <= step;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign prbs       = prbs_q;
    assign prbs_valid = valid_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_prbs_gen_multi.sv
// tb_prbs_gen_multi: scoreboard bench for prbs_gen_multi at WIDTH=8 against a bit-serial LFSR model.
module tb_prbs_gen_multi;
    localparam logic [30:0] SEED = 31'h7FFFFFFF;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  poly_sel = 2'b00;
    logic        seed_load = 1'b0;
    logic [30:0] seed = '0;
    logic        inj_err = 1'b0;
    logic [15:0] err_period = '0;
    logic [7:0]  prbs;
    logic        prbs_valid;
    logic [31:0] err_cnt;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got;
    logic [30:0] m_state;
    logic [30:0] m_mask;
    int          m_n, m_m;

    prbs_gen_multi #(.WIDTH(8), .SEED(SEED), .PER_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .poly_sel(poly_sel), .seed_load(seed_load),
        .seed(seed), .inj_err(inj_err), .err_period(err_period),
        .prbs(prbs), .prbs_valid(prbs_valid), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_init(input logic [30:0] s, input int n, input int m);
        m_n     = n;
        m_m     = m;
        m_mask  = 31'((32'h1 << n) - 32'h1);
        m_state = s & m_mask;
        if (m_state == '0) m_state = m_mask;
    endfunction

    function automatic logic [7:0] model_word();
        logic [7:0] w;
        logic       b;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            b       = m_state[m_n-1] ^ m_state[m_m-1];
            m_state = ((m_state << 1) | 31'(b)) & m_mask;
            w[i]    = b;
        end
        return w;
    endfunction

    task automatic do_reset();
        en = 0; seed_load = 0; inj_err = 0; err_period = '0; poly_sel = 2'b00;
        reset = 1;
        #7;
        reset = 0;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        n_assert++;
        if (prbs !== 8'h00 || prbs_valid !== 1'b0 || err_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: prbs=%h valid=%b err_cnt=%0d, want 00/0/0", prbs, prbs_valid, err_cnt);
        end
        do_reset();
        model_init(SEED, 31, 28);
        en = 1;
        exp_q.push_back(model_word());
        @(posedge clk); #1;
        en = 0;
        got = exp_q.pop_front();
        n_assert++;
        if (prbs_valid !== 1'b1 || prbs !== got) begin
            n_fail++;
            $display("FAIL reset_prbs31_first: prbs=%h valid=%b, want %h valid 1", prbs, prbs_valid, got);
        end
    endtask

    task automatic test_first_word();
        do_reset();
        poly_sel = 2'b00; seed = 31'h7F; seed_load = 1;
        @(posedge clk); #1;
        seed_load = 0;
        n_assert++;
        if (prbs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seedload_valid: valid=%b, want 0", prbs_valid);
        end
        model_init(31'h7F, 7, 6);
        en = 1;
        exp_q.push_back(model_word());
        @(posedge clk); #1;
        en = 0;
        got = exp_q.pop_front();
        n_assert++;
        if (prbs_valid !== 1'b1 || prbs !== got || prbs !== 8'h02) begin
            n_fail++;
            $display("FAIL prbs7_first_word: prbs=%h valid=%b, want 02 (model %h) valid 1", prbs, prbs_valid, got);
        end
        @(posedge clk); #1;
        n_assert++;
        if (prbs_valid !== 1'b0 || prbs !== 8'h02) begin
            n_fail++;
            $display("FAIL hold_when_idle: prbs=%h valid=%b, want 02 valid 0", prbs, prbs_valid);
        end
    endtask

    task automatic test_prbs7_period();
        logic [7:0] first;
        int         bad;
        bad = 0;
        first = '0;
        poly_sel = 2'b00; seed = 31'h7F; seed_load = 1;
        @(posedge clk); #1;
        seed_load = 0;
        model_init(31'h7F, 7, 6);
        en = 1;
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back(model_word());
            @(posedge clk); #1;
            got = exp_q.pop_front();
            if (k == 0) first = prbs;
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL prbs7_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        en = 0;
        n_assert++;
        if (prbs !== first || prbs !== 8'h02) begin
            n_fail++;
            $display("FAIL prbs7_wrap_word128: prbs=%h, want word1 %h and 02", prbs, first);
        end
    endtask

    task automatic test_single_inject();
        do_reset();
        inj_err = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_assert++;
            if (prbs_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL inj_idle_valid: valid=%b, want 0", prbs_valid);
            end
        end
        inj_err = 0;
        model_init(SEED, 31, 28);
        en = 1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(model_word() ^ 8'(k == 0));
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                $display("FAIL single_inj_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        en = 0;
        n_assert++;
        if (err_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL single_inj_cnt: err_cnt=%0d, want 1", err_cnt);
        end
    endtask

    task automatic test_periodic();
        do_reset();
        model_init(SEED, 31, 28);
        err_period = 16'd4;
        en = 1;
        for (int k = 0; k < 25; k++) begin
            if (k == 20) begin
                en = 0;
                @(posedge clk); #1;
                n_assert++;
                if (err_cnt !== 32'd5) begin
                    n_fail++;
                    $display("FAIL periodic_cnt20: err_cnt=%0d, want 5", err_cnt);
                end
                en = 1;
            end
            inj_err = (k == 22);
            exp_q.push_back(model_word() ^ 8'(((k + 1) % 4) == 0));
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                $display("FAIL periodic_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        en = 0; inj_err = 0; err_period = '0;
        n_assert++;
        if (err_cnt !== 32'd6) begin
            n_fail++;
            $display("FAIL periodic_plus_inj_cnt: err_cnt=%0d, want 6", err_cnt);
        end
    endtask

    task automatic test_zero_seed();
        logic any_nz;
        any_nz = 1'b0;
        do_reset();
        poly_sel = 2'b01; seed = 31'h0; seed_load = 1; en = 1;
        @(posedge clk); #1;
        seed_load = 0;
        n_assert++;
        if (prbs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seedload_with_en: valid=%b, want 0", prbs_valid);
        end
        model_init(31'h7FFF, 15, 14);
        poly_sel = 2'b11;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(model_word());
            @(posedge clk); #1;
            got = exp_q.pop_front();
            any_nz |= (prbs != 8'h00);
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                $display("FAIL prbs15_zero_seed_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        en = 0;
        n_assert++;
        if (!any_nz) begin
            n_fail++;
            $display("FAIL prbs15_not_locked: all words 00, want nonzero output");
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        model_init(SEED, 31, 28);
        en = 1;
        for (int k = 0; k < 3; k++) begin
            inj_err = (k == 0);
            exp_q.push_back(model_word() ^ 8'(k == 1));
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                $display("FAIL prerst_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        inj_err = 0;
        n_assert++;
        if (err_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL prerst_cnt: err_cnt=%0d, want 1", err_cnt);
        end
        #2;
        reset = 1;
        #1;
        n_assert++;
        if (prbs !== 8'h00 || prbs_valid !== 1'b0 || err_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: prbs=%h valid=%b err_cnt=%0d, want 00/0/0", prbs, prbs_valid, err_cnt);
        end
        en = 0;
        #1;
        reset = 0;
        @(posedge clk); #1;
        model_init(SEED, 31, 28);
        en = 1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(model_word());
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_assert++;
            if (prbs_valid !== 1'b1 || prbs !== got) begin
                n_fail++;
                $display("FAIL restart_word%0d: prbs=%h valid=%b, want %h", k + 1, prbs, prbs_valid, got);
            end
        end
        en = 0;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_prbs7_period();
        test_single_inject();
        test_periodic();
        test_zero_seed();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
